// File: rtl/mem_arb_if.sv
// Bus bundle between the two requesters (fetch, load/store), the arbiter and
// the single-ported memory. The arbiter connects through the slave modport;
// the requester/memory side connects through the master modport.
interface mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  // fetch requester
  logic          req_i;
  logic [AW-1:0] addr_i;
  logic          done_i;
  // load/store requester
  logic          req_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          done_d;
  // shared return path and status
  logic [DW-1:0] rdata;
  logic          busy;
  // memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req_i, addr_i, req_d, we_d, addr_d, wdata_d, mem_rdata,
    output done_i, done_d, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_i, addr_i, req_d, we_d, addr_d, wdata_d, mem_rdata,
    input  done_i, done_d, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb.sv
// Fetch / load-store arbiter for the single-ported memory.
// IDLE picks a winner and latches its operands, ACCESS holds the memory port
// for WAIT_CYC cycles and captures read data in the last one, DONE pulses the
// owner's done for one cycle. Data normally wins ties, but after STARVE_MAX
// consecutive data wins with fetch waiting, fetch is given the next slot.
module mem_arb #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int WAIT_CYC   = 2,
  parameter int STARVE_MAX = 3
) (
  input logic       clk,
  input logic       rst_f,
  mem_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT   = 4'(WAIT_CYC - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t        state_reg, state_next;
  logic          owner_d_reg;   // 1: current transfer belongs to data side
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rdata_reg;
  logic [3:0]    cnt_reg;
  logic [3:0]    streak_reg;
  logic          grant;         // arbitration happens this cycle
  logic          grant_d;       // winner is the data side

  // Next-state and winner selection; arbitration only happens in IDLE
  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    grant_d    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_i || bus.req_d) begin
          grant      = 1'b1;
          grant_d    = bus.req_d && (!bus.req_i || (streak_reg != STARVE_LIM));
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any transfer in flight
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand latch, wait counter, starvation streak and read-data capture
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      owner_d_reg <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      cnt_reg     <= 4'd0;
      streak_reg  <= 4'd0;
    end else begin
      if (grant) begin
        owner_d_reg <= grant_d;
        we_reg      <= grant_d & bus.we_d;   // fetch is always a read
        addr_reg    <= grant_d ? bus.addr_d : bus.addr_i;
        wdata_reg   <= grant_d ? bus.wdata_d : '0;
        cnt_reg     <= CNT_INIT;
        // streak only grows while fetch is actually being held off
        if (!grant_d || !bus.req_i) begin
          streak_reg <= 4'd0;
        end else if (streak_reg != 4'hF) begin
          streak_reg <= 4'(streak_reg + 4'd1);
        end
      end else if ((state_reg == ACCESS) && (cnt_reg != 4'd0)) begin
        cnt_reg <= 4'(cnt_reg - 4'd1);
      end
      if ((state_reg == ACCESS) && (cnt_reg == 4'd0) && !we_reg) begin
        rdata_reg <= bus.mem_rdata;
      end
    end
  end

  // Outputs decode straight from state so reset clears them without a clock
  assign bus.mem_en    = (state_reg == ACCESS);
  assign bus.mem_we    = (state_reg == ACCESS) && we_reg;
  assign bus.mem_addr  = (state_reg == ACCESS) ? addr_reg  : '0;
  assign bus.mem_wdata = (state_reg == ACCESS) ? wdata_reg : '0;
  assign bus.done_i    = (state_reg == DONE) && !owner_d_reg;
  assign bus.done_d    = (state_reg == DONE) && owner_d_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.rdata     = rdata_reg;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: one instance with WAIT_CYC=2/STARVE_MAX=3 and a
// second with WAIT_CYC=1 for back-to-back fetch timing. Each has a small
// behavioural memory indexed by the low address byte.
module tb_mem_arb;
  logic clk = 1'b0;
  logic rst_f = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_arb_if #(.AW(16), .DW(32)) bus0 ();
  mem_arb_if #(.AW(16), .DW(32)) bus1 ();

  mem_arb #(.AW(16), .DW(32), .WAIT_CYC(2), .STARVE_MAX(3)) u_dut0 (
    .clk(clk), .rst_f(rst_f), .bus(bus0.slave));
  mem_arb #(.AW(16), .DW(32), .WAIT_CYC(1), .STARVE_MAX(3)) u_dut1 (
    .clk(clk), .rst_f(rst_f), .bus(bus1.slave));

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];

  // memory models: preload while in reset, otherwise accept DUT writes
  always @(posedge clk) begin
    if (!rst_f) begin
      mem0[16] <= 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) mem1[64 + k] <= 32'hA000_0000 + k;
    end else begin
      if (bus0.mem_en && bus0.mem_we) mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
      if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    end
  end

  assign bus0.mem_rdata = mem0[bus0.mem_addr[7:0]];
  assign bus1.mem_rdata = mem1[bus1.mem_addr[7:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic seen_busy;
    rst_f = 1'b0;
    bus0.req_i = 0; bus0.addr_i = '0; bus0.req_d = 0; bus0.we_d = 0; bus0.addr_d = '0; bus0.wdata_d = '0;
    bus1.req_i = 0; bus1.addr_i = '0; bus1.req_d = 0; bus1.we_d = 0; bus1.addr_d = '0; bus1.wdata_d = '0;
    repeat (3) tick();
    n_vec++;
    if ({bus0.done_i, bus0.done_d, bus0.busy, bus0.mem_en, bus0.mem_we} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl0 got %b exp 00000", {bus0.done_i, bus0.done_d, bus0.busy, bus0.mem_en, bus0.mem_we});
    end
    n_vec++;
    if (bus0.rdata !== 32'h0 || bus0.mem_addr !== 16'h0 || bus0.mem_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data0 got rdata=%h addr=%h wdata=%h exp all 0", bus0.rdata, bus0.mem_addr, bus0.mem_wdata);
    end
    n_vec++;
    if ({bus1.done_i, bus1.done_d, bus1.busy, bus1.mem_en, bus1.mem_we} !== 5'b0 || bus1.rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_dut1 got ctrl=%b rdata=%h exp 0", {bus1.done_i, bus1.done_d, bus1.busy, bus1.mem_en, bus1.mem_we}, bus1.rdata);
    end
    rst_f = 1'b1;
    seen_busy = 1'b0;
    repeat (4) begin
      tick();
      if (bus0.busy || bus1.busy) seen_busy = 1'b1;
    end
    n_vec++;
    if (seen_busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_busy got %b exp 0", seen_busy);
    end
    $display("txn reset: outputs checked in reset and idle after release");
  endtask

  task automatic test_fetch_read();
    bus0.req_i = 1'b1; bus0.addr_i = 16'h0010;
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_vec++;
      if ({bus0.mem_en, bus0.mem_we, bus0.busy, bus0.done_i, bus0.done_d} !== 5'b10100 || bus0.mem_addr !== 16'h0010) begin
        n_err++;
        $display("FAIL fetch_access_c%0d got ctrl=%b addr=%h exp ctrl=10100 addr=0010", c,
                 {bus0.mem_en, bus0.mem_we, bus0.busy, bus0.done_i, bus0.done_d}, bus0.mem_addr);
      end
    end
    tick();
    n_vec++;
    if ({bus0.mem_en, bus0.mem_we, bus0.busy, bus0.done_i, bus0.done_d} !== 5'b00110 || bus0.mem_addr !== 16'h0) begin
      n_err++;
      $display("FAIL fetch_done got ctrl=%b addr=%h exp ctrl=00110 addr=0000",
               {bus0.mem_en, bus0.mem_we, bus0.busy, bus0.done_i, bus0.done_d}, bus0.mem_addr);
    end
    n_vec++;
    if (bus0.rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL fetch_rdata got %h exp deadbeef", bus0.rdata);
    end
    bus0.req_i = 1'b0;
    tick();
    n_vec++;
    if (bus0.busy !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_back_idle got busy=%b exp 0", bus0.busy);
    end
    $display("txn fetch read addr=0010 rdata=%h", bus0.rdata);
  endtask

  task automatic test_write_read();
    bus0.req_d = 1'b1; bus0.we_d = 1'b1; bus0.addr_d = 16'h0020; bus0.wdata_d = 32'h12345678;
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_vec++;
      if ({bus0.mem_en, bus0.mem_we, bus0.busy, bus0.done_i, bus0.done_d} !== 5'b11100 ||
          bus0.mem_addr !== 16'h0020 || bus0.mem_wdata !== 32'h12345678) begin
        n_err++;
        $display("FAIL write_access_c%0d got ctrl=%b addr=%h wdata=%h exp ctrl=11100 addr=0020 wdata=12345678", c,
                 {bus0.mem_en, bus0.mem_we, bus0.busy, bus0.done_i, bus0.done_d}, bus0.mem_addr, bus0.mem_wdata);
      end
    end
    tick();
    n_vec++;
    if ({bus0.mem_en, bus0.mem_we, bus0.busy, bus0.done_i, bus0.done_d} !== 5'b00101 || bus0.rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_done got ctrl=%b rdata=%h exp ctrl=00101 rdata=deadbeef",
               {bus0.mem_en, bus0.mem_we, bus0.busy, bus0.done_i, bus0.done_d}, bus0.rdata);
    end
    bus0.req_d = 1'b0; bus0.we_d = 1'b0; bus0.wdata_d = '0;
    tick();
    n_vec++;
    if (mem0[32] !== 32'h12345678) begin
      n_err++;
      $display("FAIL write_mem got %h exp 12345678", mem0[32]);
    end
    $display("txn data write addr=0020 wdata=12345678");
    bus0.req_d = 1'b1;
    tick();
    n_vec++;
    if ({bus0.mem_en, bus0.mem_we, bus0.busy} !== 3'b101) begin
      n_err++;
      $display("FAIL read_access got en/we/busy=%b exp 101", {bus0.mem_en, bus0.mem_we, bus0.busy});
    end
    tick();
    tick();
    n_vec++;
    if ({bus0.done_i, bus0.done_d} !== 2'b01 || bus0.rdata !== 32'h12345678) begin
      n_err++;
      $display("FAIL read_done got done_i/d=%b rdata=%h exp 01 12345678", {bus0.done_i, bus0.done_d}, bus0.rdata);
    end
    bus0.req_d = 1'b0;
    tick();
    $display("txn data read addr=0020 rdata=%h", bus0.rdata);
  endtask

  task automatic test_starve();
    logic [7:0] exp_d;
    logic both_seen;
    logic got;
    int   lat;
    exp_d = 8'b0111_0111;   // bit g = 1 when grant g should go to data: D,D,D,I,D,D,D,I
    both_seen = 1'b0;
    bus0.req_i = 1'b1; bus0.addr_i = 16'h0010;
    bus0.req_d = 1'b1; bus0.we_d = 1'b0; bus0.addr_d = 16'h0020;
    for (int g = 0; g < 8; g++) begin
      got = 1'b0; lat = 0;
      while (!got && lat < 10) begin
        tick();
        lat++;
        if (bus0.done_i && bus0.done_d) both_seen = 1'b1;
        if (bus0.done_i || bus0.done_d) got = 1'b1;
      end
      n_vec++;
      if (!got) begin
        n_err++;
        $display("FAIL starve_timeout grant %0d got no done exp done", g);
      end else begin
        n_vec++;
        if (bus0.done_d !== exp_d[g]) begin
          n_err++;
          $display("FAIL starve_order grant %0d got done_d=%b exp %b", g, bus0.done_d, exp_d[g]);
        end
        n_vec++;
        if (bus0.rdata !== (exp_d[g] ? 32'h12345678 : 32'hDEADBEEF)) begin
          n_err++;
          $display("FAIL starve_rdata grant %0d got %h", g, bus0.rdata);
        end
        n_vec++;
        if (lat != ((g == 0) ? 3 : 4)) begin
          n_err++;
          $display("FAIL starve_spacing grant %0d got %0d cycles exp %0d", g, lat, (g == 0) ? 3 : 4);
        end
      end
      $display("txn grant %0d -> %s rdata=%h", g, bus0.done_d ? "D" : "I", bus0.rdata);
    end
    bus0.req_i = 1'b0; bus0.req_d = 1'b0;
    tick();
    tick();
    n_vec++;
    if (both_seen !== 1'b0) begin
      n_err++;
      $display("FAIL starve_both_done got %b exp 0", both_seen);
    end
  endtask

  task automatic test_reset_mid();
    logic done_seen;
    logic got;
    int   lat;
    bus0.req_d = 1'b1; bus0.we_d = 1'b1; bus0.addr_d = 16'h0030; bus0.wdata_d = 32'hCAFEF00D;
    tick();
    n_vec++;
    if ({bus0.mem_en, bus0.mem_we} !== 2'b11) begin
      n_err++;
      $display("FAIL abort_pre got en/we=%b exp 11", {bus0.mem_en, bus0.mem_we});
    end
    #2 rst_f = 1'b0;
    #1;
    n_vec++;
    if ({bus0.mem_en, bus0.mem_we, bus0.busy} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_async got en/we/busy=%b exp 000", {bus0.mem_en, bus0.mem_we, bus0.busy});
    end
    bus0.req_d = 1'b0; bus0.we_d = 1'b0; bus0.wdata_d = '0;
    done_seen = 1'b0;
    repeat (2) begin
      tick();
      if (bus0.done_d || bus0.done_i) done_seen = 1'b1;
    end
    #2 rst_f = 1'b1;
    tick();
    if (bus0.done_d || bus0.done_i) done_seen = 1'b1;
    n_vec++;
    if (done_seen !== 1'b0 || bus0.rdata !== 32'h0) begin
      n_err++;
      $display("FAIL abort_nodone got done_seen=%b rdata=%h exp 0 0", done_seen, bus0.rdata);
    end
    $display("txn data write addr=0030 aborted by reset");
    bus0.req_i = 1'b1; bus0.addr_i = 16'h0010;
    got = 1'b0; lat = 0;
    while (!got && lat < 10) begin
      tick();
      lat++;
      if (bus0.done_i) got = 1'b1;
    end
    n_vec++;
    if (!got || lat != 3 || bus0.rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL abort_refetch got done=%b lat=%0d rdata=%h exp 1 3 deadbeef", got, lat, bus0.rdata);
    end
    bus0.req_i = 1'b0;
    tick();
    $display("txn fetch after reset lat=%0d rdata=%h", lat, bus0.rdata);
  endtask

  task automatic test_back_to_back();
    logic got;
    logic addr_bad;
    int   lat;
    bus1.req_i = 1'b1; bus1.addr_i = 16'h0040;
    for (int t = 0; t < 4; t++) begin
      got = 1'b0; lat = 0; addr_bad = 1'b0;
      while (!got && lat < 10) begin
        tick();
        lat++;
        if (bus1.mem_en && bus1.mem_addr !== 16'(16'h0040 + t)) addr_bad = 1'b1;
        if (bus1.done_i) got = 1'b1;
      end
      n_vec++;
      if (!got || lat != ((t == 0) ? 2 : 3)) begin
        n_err++;
        $display("FAIL b2b_timing xfer %0d got done=%b lat=%0d exp 1 %0d", t, got, lat, (t == 0) ? 2 : 3);
      end
      n_vec++;
      if (addr_bad !== 1'b0 || bus1.rdata !== 32'(32'hA000_0000 + t)) begin
        n_err++;
        $display("FAIL b2b_data xfer %0d got addr_bad=%b rdata=%h exp 0 %h", t, addr_bad, bus1.rdata, 32'hA000_0000 + t);
      end
      $display("txn b2b fetch %0d addr=%h rdata=%h lat=%0d", t, 16'h0040 + t, bus1.rdata, lat);
      bus1.addr_i = 16'(16'h0041 + t);
    end
    bus1.req_i = 1'b0;
    tick();
    tick();
    n_vec++;
    if (bus1.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle got busy=%b exp 0", bus1.busy);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_write_read();
    test_starve();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Sequential arbiter that shares the single-ported SISC memory between the instruction-fetch requester and the load/store data requester. Accepts level requests from both, picks one winner per access, drives the memory port for a fixed number of wait cycles, returns read data with a one-cycle done pulse, and prevents fetch starvation under back-to-back data traffic. Sits between `ctrl`/datapath and the memory model.

## Interface
- `AW`, 16, address width
- `DW`, 32, data width
- `WAIT_CYC`, 2, memory access cycles per transfer; legal range 1..15
- `STARVE_MAX`, 3, consecutive data wins allowed while fetch waits; legal range 1..15

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_f`  in  1  reset, asynchronous, active-low
- `req_i`  in  1  fetch request (level, read only)
- `addr_i`  in  AW  fetch address
- `req_d`  in  1  data request (level)
- `we_d`  in  1  data request is a write
- `addr_d`  in  AW  data address
- `wdata_d`  in  DW  data write value
- `done_i`  out  1  one-cycle pulse: fetch transfer complete
- `done_d`  out  1  one-cycle pulse: data transfer complete
- `rdata`  out  DW  registered read data, valid while `done_*` high
- `busy`  out  1  high in ACCESS and DONE
- `mem_en`  out  1  memory enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid in last ACCESS cycle

## Operation
- States: IDLE, ACCESS, DONE. Reset → IDLE.
- IDLE: if neither request, stay. Otherwise choose winner, latch owner, address, we (0 for fetch), wdata; load wait counter with WAIT_CYC-1; → ACCESS.
- Winner rule: only one requesting → it wins. Both requesting → data wins unless streak == STARVE_MAX, in which case fetch wins.
- Streak counter (4 bits): +1 on each data win while `req_i` high at arbitration; cleared on any fetch win or when data wins with `req_i` low. Saturates, never wraps.
- ACCESS: `mem_en`=1, `mem_addr`/`mem_wdata` from latched values, `mem_we`=latched we. Counter decrements each cycle; at counter 0 capture `mem_rdata` into `rdata` (reads only), → DONE.
- DONE: pulse `done_i` or `done_d` per owner; `mem_en`=`mem_we`=0; → IDLE unconditionally.
- Writes leave `rdata` unchanged.
- Requesters hold req and operands stable until their done pulse; requester must drop req the cycle after done or it is arbitrated again as a new request. Operand changes during ACCESS are ignored (latched).
- `mem_addr`, `mem_wdata` are 0 outside ACCESS.

## Timing
- Reset values: all outputs 0, state IDLE, streak 0, counter 0, `rdata` 0.
- Reset asserted mid-access: immediate return to IDLE, transfer aborted, no done pulse, `mem_en` drops asynchronously.
- Request sampled in IDLE cycle 0 → ACCESS cycles 1..WAIT_CYC → DONE cycle WAIT_CYC+1. Latency req→done = WAIT_CYC+1 cycles; throughput one transfer per WAIT_CYC+2 cycles.
- No arbitration in ACCESS or DONE; requests arriving then wait until IDLE.
- Simultaneous requests in same IDLE cycle resolved by winner rule; loser stays pending, no done.
- WAIT_CYC=1: single ACCESS cycle, capture in that cycle.
- Exactly one of `done_i`/`done_d` high in DONE; never both.

## Test plan
- Reset: hold `rst_f`=0, toggle clk → all outputs 0; release, no requests → `busy` stays 0.
- Single fetch read, WAIT_CYC=2, addr_i=0x0010, memory[0x0010]=0xDEADBEEF → `mem_en` high cycles 1–2, `done_i` at cycle 3, `rdata`=0xDEADBEEF.
- Data write addr_d=0x0020, wdata_d=0x12345678 then data read same address → `mem_we` high only during write ACCESS; read `done_d` returns 0x12345678; `rdata` unchanged after write.
- Both requests held continuously, STARVE_MAX=3 → grant order D,D,D,I,D,D,D,I…; no two done pulses in one cycle.
- Assert `rst_f`=0 during ACCESS of a data write → `mem_en`/`mem_we` drop immediately, no `done_d`; after release, a new fetch completes normally in WAIT_CYC+1 cycles.
- WAIT_CYC=1 back-to-back fetches with `req_i` held → `done_i` every 3 cycles, addresses tracked per transfer.
